// File: rtl/fpro_init_pkg.sv
// ============================================================================
//  Package     : fpro_init_pkg
//  Description : Shared types and constants for the FPro MMIO initiator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpro_init_pkg;

  localparam int FPRO_ADDR_W = 21;
  localparam int FPRO_DATA_W = 32;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fpro_mmio_initiator.sv
// ============================================================================
//  Module      : fpro_mmio_initiator
//  Description : Command-driven FPro MMIO bus master with read/write bursts.
//                Macro FPRO_INIT_BURST_EN enables multi-beat commands.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpro_mmio_initiator
  import fpro_init_pkg::*;
#(
  parameter int ADDR_W = FPRO_ADDR_W,
  parameter int DATA_W = FPRO_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [7:0]        cmd_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              mmio_cs,
  output logic              mmio_wr,
  output logic              mmio_rd,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [DATA_W-1:0] mmio_wr_data,
  input  logic [DATA_W-1:0] mmio_rd_data,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              last_q, last_d;
  logic              final_beat;

`ifdef FPRO_INIT_BURST_EN
  logic [7:0] cnt_q, cnt_d;
  assign final_beat = (cnt_q == 8'd0);
`else
  // Single-beat build: the length field is accepted but has no effect.
  logic unused_len;
  assign unused_len = ^cmd_len;
  assign final_beat = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    last_d  = last_q;
`ifdef FPRO_INIT_BURST_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_ISSUE;
          wr_d    = cmd_wr;
          addr_d  = cmd_addr;
          wdata_d = (cmd_wr == OP_WR) ? cmd_wdata : '0;
`ifdef FPRO_INIT_BURST_EN
          cnt_d   = cmd_len;
`endif
        end
      end
      ST_ISSUE: begin
        if (wr_q == OP_WR) begin
          // Writes stream without per-beat responses; one response at the end.
          if (final_beat) begin
            state_d = ST_RESP;
            rdata_d = '0;
            last_d  = 1'b1;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
`ifdef FPRO_INIT_BURST_EN
            cnt_d   = cnt_q - 8'd1;
`endif
          end
        end else begin
          state_d = ST_RESP;
          rdata_d = mmio_rd_data;
          last_d  = final_beat;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ISSUE;
            addr_d  = addr_q + ADDR_W'(1);
`ifdef FPRO_INIT_BURST_EN
            cnt_d   = cnt_q - 8'd1;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wr_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      last_q  <= 1'b0;
`ifdef FPRO_INIT_BURST_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
`ifdef FPRO_INIT_BURST_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign mmio_cs      = (state_q == ST_ISSUE);
  assign mmio_wr      = (state_q == ST_ISSUE) && (wr_q == OP_WR);
  assign mmio_rd      = (state_q == ST_ISSUE) && (wr_q == OP_RD);
  assign mmio_addr    = addr_q;
  assign mmio_wr_data = (state_q == ST_ISSUE) ? wdata_q : '0;
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_rdata    = rdata_q;
  assign rsp_last     = last_q;

endmodule

`default_nettype wire

// File: tb/tb_fpro_mmio_initiator.sv
// ============================================================================
//  Module      : tb_fpro_mmio_initiator
//  Description : Randomized self-checking bench for fpro_mmio_initiator.
//                Honours FPRO_INIT_BURST_EN when building expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpro_mmio_initiator;

  localparam int AW = 21;
  localparam int DW = 32;
`ifdef FPRO_INIT_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [7:0]    cmd_len;
  logic          rsp_valid, rsp_ready, rsp_last;
  logic [DW-1:0] rsp_rdata;
  logic          mmio_cs, mmio_wr, mmio_rd;
  logic [AW-1:0] mmio_addr;
  logic [DW-1:0] mmio_wr_data, mmio_rd_data;
  logic          busy;

  logic          use_ovr;
  logic [DW-1:0] ovr_data;

  always #5 clk = ~clk;

  fpro_mmio_initiator dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last), .mmio_cs(mmio_cs), .mmio_wr(mmio_wr),
    .mmio_rd(mmio_rd), .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_data(mmio_rd_data), .busy(busy)
  );

  // Slave memory contents are a fixed hash of the word address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h0F1E2D3C;
  endfunction

  assign mmio_rd_data = !mmio_rd ? 32'hBAD0BAD0 :
                        (use_ovr ? ovr_data : mem_word(mmio_addr));

  typedef struct packed {
    int            cyc;
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } strb_t;

  typedef struct packed {
    int            cyc;
    logic          last;
    logic [DW-1:0] data;
  } rsp_t;

  strb_t obs_strb[$], exp_strb[$];
  rsp_t  obs_rsp[$],  exp_rsp[$];
  int    stab_err, proto_err, done_cyc;
  int    chk_cnt = 0;
  int    pass_cnt = 0;

  // Presents one command at the current negedge, then observes it to completion.
  // Cycle 0 is the first cycle after the accepting edge.
  task automatic do_cmd(input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [7:0] len,
                        input int stall, input bit junk);
    int            waitc;
    bit            held;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    strb_t         s;
    rsp_t          r;
    obs_strb.delete(); obs_rsp.delete();
    stab_err = 0; proto_err = 0; done_cyc = -1;
    waitc = 0; held = 0; prev_d = '0; prev_l = 1'b0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_len = len;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (!busy) begin
        done_cyc = k;
        break;
      end
      if (cmd_ready) proto_err++;
      if ((mmio_cs !== (mmio_wr | mmio_rd)) || (mmio_wr & mmio_rd)) proto_err++;
      if (rsp_valid && mmio_cs) proto_err++;
      if (mmio_cs) begin
        s = '{cyc: k, wr: mmio_wr, rd: mmio_rd, addr: mmio_addr, data: mmio_wr_data};
        obs_strb.push_back(s);
      end
      if (rsp_valid) begin
        if (held && (rsp_rdata !== prev_d || rsp_last !== prev_l)) stab_err++;
        if (waitc < stall) begin
          rsp_ready = 1'b0; waitc++; held = 1'b1;
          prev_d = rsp_rdata; prev_l = rsp_last;
        end else begin
          rsp_ready = 1'b1;
          r = '{cyc: k, last: rsp_last, data: rsp_rdata};
          obs_rsp.push_back(r);
          waitc = 0; held = 1'b0;
        end
      end else begin
        if (held) stab_err++;
        held = 1'b0;
        rsp_ready = 1'($urandom);
      end
      if (junk) begin
        cmd_valid = 1'($urandom); cmd_wr = 1'($urandom); cmd_addr = AW'($urandom);
        cmd_wdata = $urandom; cmd_len = 8'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({cmd_ready, busy, mmio_cs, mmio_wr, mmio_rd, rsp_valid, rsp_last} !== 7'b1000000)
      $display("FAIL reset_ctrl: got %b expected 1000000",
               {cmd_ready, busy, mmio_cs, mmio_wr, mmio_rd, rsp_valid, rsp_last});
    else pass_cnt++;
    chk_cnt++;
    if (mmio_addr !== '0) $display("FAIL reset_addr: got %h expected 0", mmio_addr);
    else pass_cnt++;
    chk_cnt++;
    if (mmio_wr_data !== '0) $display("FAIL reset_wdata: got %h expected 0", mmio_wr_data);
    else pass_cnt++;
    chk_cnt++;
    if (rsp_rdata !== '0) $display("FAIL reset_rdata: got %h expected 0", rsp_rdata);
    else pass_cnt++;
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    strb_t s0;
    rsp_t  r0;
    use_ovr = 1'b1; ovr_data = 32'hDEADBEEF;
    do_cmd(1'b0, 21'h00040, 32'h0, 8'd0, 0, 1'b0);
    use_ovr = 1'b0;
    chk_cnt++;
    if (obs_strb.size() != 1)
      $display("FAIL single_read_nstrb: got %0d expected 1", obs_strb.size());
    else pass_cnt++;
    s0 = (obs_strb.size() > 0) ? obs_strb[0] : '0;
    chk_cnt++;
    if (s0 !== strb_t'{cyc: 0, wr: 1'b0, rd: 1'b1, addr: 21'h00040, data: 32'h0})
      $display("FAIL single_read_strobe: got %h expected cyc0 rd addr 00040", s0);
    else pass_cnt++;
    chk_cnt++;
    if (obs_rsp.size() != 1)
      $display("FAIL single_read_nrsp: got %0d expected 1", obs_rsp.size());
    else pass_cnt++;
    r0 = (obs_rsp.size() > 0) ? obs_rsp[0] : '0;
    chk_cnt++;
    if (r0 !== rsp_t'{cyc: 1, last: 1'b1, data: 32'hDEADBEEF})
      $display("FAIL single_read_rsp: got %h expected cyc1 last1 deadbeef", r0);
    else pass_cnt++;
    chk_cnt++;
    if (done_cyc != 2) $display("FAIL single_read_done: got %0d expected 2", done_cyc);
    else pass_cnt++;
  endtask

  // Directed table first (write burst, stalled read burst, wrap, ignored len),
  // then randomized commands; all issued back to back with no idle gap.
  task automatic test_commands();
    int t_wr[6]    = '{1, 0, 0, 0, 1, 0};
    int t_addr[6]  = '{32'h00060, 32'h00200, 32'h1FFFFF, 32'h00100, 32'h1FFFFE, 32'h00040};
    int t_len[6]   = '{3, 2, 1, 7, 4, 0};
    int t_stall[6] = '{0, 5, 0, 1, 2, 0};
    logic          wr;
    logic [AW-1:0] addr, a;
    logic [DW-1:0] wdata;
    logic [7:0]    len;
    int            stall, nb, exp_done;
    strb_t         s;
    rsp_t          r;
    for (int n = 0; n < 36; n++) begin
      if (n < 6) begin
        wr = 1'(t_wr[n]); addr = AW'(t_addr[n]); len = 8'(t_len[n]);
        stall = t_stall[n]; wdata = (n == 0) ? 32'h5A : $urandom;
      end else begin
        wr = 1'($urandom); wdata = $urandom; stall = $urandom_range(0, 3);
        addr = ($urandom_range(0, 3) == 0) ? AW'(21'h1FFFFF - $urandom_range(0, 4)) : AW'($urandom);
        len = BURST ? 8'($urandom_range(0, 15)) : 8'($urandom);
      end
      nb = BURST ? int'(len) + 1 : 1;
      exp_strb.delete(); exp_rsp.delete();
      for (int i = 0; i < nb; i++) begin
        a = addr + AW'(i);
        if (wr) begin
          s = '{cyc: i, wr: 1'b1, rd: 1'b0, addr: a, data: wdata};
        end else begin
          s = '{cyc: i * (2 + stall), wr: 1'b0, rd: 1'b1, addr: a, data: '0};
          r = '{cyc: i * (2 + stall) + 1 + stall, last: (i == nb - 1), data: mem_word(a)};
          exp_rsp.push_back(r);
        end
        exp_strb.push_back(s);
      end
      if (wr) begin
        r = '{cyc: nb + stall, last: 1'b1, data: '0};
        exp_rsp.push_back(r);
        exp_done = nb + 1 + stall;
      end else begin
        exp_done = nb * (2 + stall);
      end

      do_cmd(wr, addr, wdata, len, stall, 1'b1);

      chk_cnt++;
      if (done_cyc != exp_done)
        $display("FAIL cmd%0d_done: got %0d expected %0d", n, done_cyc, exp_done);
      else pass_cnt++;
      chk_cnt++;
      if (proto_err != 0) $display("FAIL cmd%0d_protocol: got %0d errors expected 0", n, proto_err);
      else pass_cnt++;
      chk_cnt++;
      if (stab_err != 0) $display("FAIL cmd%0d_rsp_stable: got %0d errors expected 0", n, stab_err);
      else pass_cnt++;
      chk_cnt++;
      if (obs_strb.size() != exp_strb.size())
        $display("FAIL cmd%0d_nstrb: got %0d expected %0d", n, obs_strb.size(), exp_strb.size());
      else pass_cnt++;
      for (int i = 0; i < exp_strb.size() && i < obs_strb.size(); i++) begin
        chk_cnt++;
        if (obs_strb[i] !== exp_strb[i])
          $display("FAIL cmd%0d_strobe%0d: got %h expected %h", n, i, obs_strb[i], exp_strb[i]);
        else pass_cnt++;
      end
      chk_cnt++;
      if (obs_rsp.size() != exp_rsp.size())
        $display("FAIL cmd%0d_nrsp: got %0d expected %0d", n, obs_rsp.size(), exp_rsp.size());
      else pass_cnt++;
      for (int i = 0; i < exp_rsp.size() && i < obs_rsp.size(); i++) begin
        chk_cnt++;
        if (obs_rsp[i] !== exp_rsp[i])
          $display("FAIL cmd%0d_rsp%0d: got %h expected %h", n, i, obs_rsp[i], exp_rsp[i]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int           extra;
    logic [AW+1:0] exp_mid;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 21'h00300; cmd_wdata = 32'hA5A5; cmd_len = 8'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk_cnt++;
    if ({mmio_cs, mmio_wr, mmio_addr} !== {2'b11, 21'h00300})
      $display("FAIL midrst_beat1: got %h expected %h", {mmio_cs, mmio_wr, mmio_addr}, {2'b11, 21'h00300});
    else pass_cnt++;
    @(negedge clk);
    exp_mid = BURST ? {1'b1, 1'b0, 21'h00301} : {1'b0, 1'b1, 21'h00300};
    chk_cnt++;
    if ({mmio_wr, rsp_valid, mmio_addr} !== exp_mid)
      $display("FAIL midrst_beat2: got %h expected %h", {mmio_wr, rsp_valid, mmio_addr}, exp_mid);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({mmio_cs, mmio_wr, mmio_rd, busy, cmd_ready, rsp_valid} !== 6'b000010)
      $display("FAIL midrst_state: got %b expected 000010",
               {mmio_cs, mmio_wr, mmio_rd, busy, cmd_ready, rsp_valid});
    else pass_cnt++;
    reset = 1'b1; rsp_ready = 1'b1;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid || mmio_cs || busy) extra++;
    end
    chk_cnt++;
    if (extra != 0) $display("FAIL midrst_residue: got %0d active cycles expected 0", extra);
    else pass_cnt++;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    use_ovr = 1'b0; ovr_data = '0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_len = '0;
    rsp_ready = 1'b0; reset = 1'b0;
    test_reset();
    test_single_read();
    test_commands();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpro_mmio_initiator.md
FPRO_MMIO_INITIATOR -- requirements
Module: fpro_mmio_initiator

Interface
REQ-001 Parameter ADDR_W, default 21, FPro MMIO word-address width.
REQ-002 Parameter DATA_W, default 32, FPro MMIO data width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low; reset asserted when reset==0 at a clk edge.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid&cmd_ready at clk edge.
REQ-007 cmd_wr  input  1  1=write, 0=read.
REQ-008 cmd_addr  input  ADDR_W  start word address.
REQ-009 cmd_wdata  input  DATA_W  write data, repeated on every write beat.
REQ-010 cmd_len  input  8  beat count minus one (0..255 -> 1..256 beats).
REQ-011 rsp_valid  output  1  response held until rsp_ready.
REQ-012 rsp_ready  input  1  response consumer ready.
REQ-013 rsp_rdata  output  DATA_W  read data; 0 for write responses.
REQ-014 rsp_last  output  1  final response of the command.
REQ-015 mmio_cs, mmio_wr, mmio_rd  output  1 each  FPro bus strobes.
REQ-016 mmio_addr  output  ADDR_W; mmio_wr_data  output  DATA_W; mmio_rd_data  input  DATA_W.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states IDLE, ISSUE, RESP; all outputs registered or decoded from registered state only.
REQ-019 IDLE: cmd_ready=1, strobes low; on handshake latch wr/addr/wdata/len, go ISSUE.
REQ-020 ISSUE: mmio_cs=1 and exactly one of mmio_wr/mmio_rd=1 for one cycle per beat, mmio_addr=current address, mmio_wr_data=latched wdata (0 on reads).
REQ-021 Latency: cmd handshake at edge N -> first strobe cycle N+1 -> first read rsp_valid cycle N+2.
REQ-022 Read beat: mmio_rd_data sampled at the edge ending the ISSUE cycle into rsp_rdata; go RESP; rsp_last=1 only on final beat.
REQ-023 RESP: rsp_valid=1, rsp_rdata/rsp_last stable until rsp_ready; on handshake, last beat -> IDLE, else address+1, count-1 -> ISSUE; no strobe in RESP.
REQ-024 Write burst: beats issued back-to-back in consecutive cycles with address+1 each; after final beat go RESP with rsp_last=1, rsp_rdata=0 (one response per write command).
REQ-025 Address increments modulo 2^ADDR_W; 0x1FFFFF+1 -> 0x000000.
REQ-026 cmd_ready=0 whenever busy=1; commands never queued; cmd_valid in ISSUE/RESP ignored.
REQ-027 rsp_ready high with no rsp_valid has no effect; rsp_ready tied high gives one read beat per 2 cycles.

Reset
REQ-028 On reset: state IDLE, cmd_ready=1, busy=0, all strobes 0, mmio_addr=0, mmio_wr_data=0, rsp_valid=0, rsp_rdata=0, rsp_last=0.
REQ-029 Reset mid-command: strobes low from the next cycle, remaining beats and pending response discarded.

Configuration
REQ-030 Macro FPRO_INIT_BURST_EN defined: cmd_len honoured as REQ-010.
REQ-031 Macro FPRO_INIT_BURST_EN undefined: cmd_len port present but ignored, every command is exactly one beat with rsp_last=1; counter logic absent.

Structure
REQ-032 Package fpro_init_pkg holds state enum, ADDR_W/DATA_W defaults and op constants OP_RD=0, OP_WR=1.
REQ-033 No sub-module; single FSM plus address/beat counters in fpro_mmio_initiator.

Verification
REQ-034 Single read addr 0x00040, bus returns 0xDEADBEEF -> one mmio_rd pulse at cycle N+1, rsp 0xDEADBEEF, rsp_last=1, cycle N+2.
REQ-035 Write burst addr 0x00060 len 3 wdata 0x5A -> 4 consecutive mmio_wr pulses addr 0x60..0x63, then one rsp, rdata 0, last=1.
REQ-036 Read burst len 2, rsp_ready low 5 cycles per beat -> rsp held stable, no extra strobes, 3 responses, last only on third.
REQ-037 Read burst addr 0x1FFFFF len 1 -> mmio_addr 0x1FFFFF then 0x000000.
REQ-038 reset low during write burst beat 2 of 4 -> strobes 0 next cycle, busy=0, cmd_ready=1, no response.
REQ-039 FPRO_INIT_BURST_EN undefined, cmd_len=7 -> single beat, rsp_last=1.
